// File: rtl/restoring_divider.sv
// restoring_divider
//   Sequential restoring divider. Each RUN cycle shifts the partial
//   remainder/quotient pair {A,Q} left by one and trial-subtracts the divisor.
//   Latency is WIDTH+1 cycles from the accepting edge, or 1 cycle for a zero
//   divisor. All outputs are registered.
//
//   Optional feature macro: RESTORING_DIVIDER_SIGNED_EN
//     defined   -> two's complement operands, truncating division
//     undefined -> unsigned operands, no sign logic built
//
//   Ports
//     clk          in   rising-edge clock
//     rst_n        in   asynchronous active-low reset
//     start        in   request, sampled only while busy is low
//     dividend     in   [WIDTH] captured on the accepting edge
//     divisor      in   [WIDTH] captured on the accepting edge
//     busy         out  high from the accepting edge until the result edge
//     done         out  one-cycle pulse, results valid
//     quotient     out  [WIDTH] held until the next result edge
//     remainder    out  [WIDTH] held until the next result edge
//     div_by_zero  out  set with done when the divisor was 0
module restoring_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_e;

  state_e             state_q, state_d;
  logic [WIDTH:0]     a_q, a_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               dz_q, dz_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   quot_q, quot_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic               dzo_q, dzo_d;
`ifdef RESTORING_DIVIDER_SIGNED_EN
  logic               negq_q, negq_d;   // operand signs differ
  logic               negr_q, negr_d;   // dividend was negative
`endif

  // One iteration's datapath. The MSB of A shifts out of the 2W+1-bit pair;
  // it is always 0 after a restore since A < M.
  logic [2*WIDTH:0]   sh;
  logic [WIDTH:0]     a_sh;
  logic [WIDTH-1:0]   q_sh;
  logic [WIDTH:0]     t;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
`ifdef RESTORING_DIVIDER_SIGNED_EN
    // Most-negative value maps to itself, which is its correct unsigned magnitude.
    mag = x[WIDTH-1] ? -x : x;
`else
    mag = x;
`endif
  endfunction

  always_comb begin
    sh      = {a_q, q_q} << 1;
    a_sh    = sh[2*WIDTH:WIDTH];
    q_sh    = sh[WIDTH-1:0];
    t       = a_sh - {1'b0, m_q};

    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    dz_d    = dz_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dzo_d   = dzo_q;
`ifdef RESTORING_DIVIDER_SIGNED_EN
    negq_d  = negq_q;
    negr_d  = negr_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d    = '0;
          cnt_d  = '0;
          m_d    = mag(divisor);
          busy_d = 1'b1;
`ifdef RESTORING_DIVIDER_SIGNED_EN
          negq_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
          negr_d = dividend[WIDTH-1];
`endif
          if (divisor == '0) begin
            // Keep the raw dividend in Q; it becomes the remainder as-is.
            q_d     = dividend;
            dz_d    = 1'b1;
            state_d = FINISH;
          end else begin
            q_d     = mag(dividend);
            dz_d    = 1'b0;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (t[WIDTH]) begin
          a_d = a_sh;                   // restore
          q_d = {q_sh[WIDTH-1:1], 1'b0};
        end else begin
          a_d = t;
          q_d = {q_sh[WIDTH-1:1], 1'b1};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = FINISH;
      end
      FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        dzo_d   = dz_q;
        state_d = IDLE;
        if (dz_q) begin
          quot_d = '1;
          rem_d  = q_q;
        end else begin
`ifdef RESTORING_DIVIDER_SIGNED_EN
          quot_d = negq_q ? -q_q : q_q;
          rem_d  = negr_q ? -a_q[WIDTH-1:0] : a_q[WIDTH-1:0];
`else
          quot_d = q_q;
          rem_d  = a_q[WIDTH-1:0];
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dzo_q   <= 1'b0;
`ifdef RESTORING_DIVIDER_SIGNED_EN
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      dz_q    <= dz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dzo_q   <= dzo_d;
`ifdef RESTORING_DIVIDER_SIGNED_EN
      negq_q  <= negq_d;
      negr_q  <= negr_d;
`endif
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dzo_q;

endmodule

// File: doc/restoring_divider.md
# restoring_divider

Sequential restoring divider for the arithmetic lab datapath. It is the division counterpart of the right-shifting Booth multiplier: it left-shifts the concatenated partial-remainder/quotient register {A, Q} once per cycle and trial-subtracts the divisor to produce quotient and remainder. It takes a start/done handshake and sits beside the multiplier in the ALU's multi-cycle unit.

## Interface
- `WIDTH`, default 8: operand, quotient and remainder width in bits (≥ 2).

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  request; sampled only when `busy` = 0
- `dividend`  in  WIDTH  dividend, captured on the accepting edge
- `divisor`  in  WIDTH  divisor, captured on the accepting edge
- `busy`  out  1  high from the accepting edge until the result edge
- `done`  out  1  one-cycle pulse; results valid
- `quotient`  out  WIDTH  quotient, held until the next result edge
- `remainder`  out  WIDTH  remainder, held until the next result edge
- `div_by_zero`  out  1  set with `done` when divisor was 0; held with the results

## Operation
- FSM states: IDLE, RUN, FINISH.
- Internal registers:
  - A, WIDTH+1 bits, one extra bit for the subtraction sign.
  - Q and M, WIDTH bits each.
  - Iteration counter, clog2(WIDTH+1) bits.
- IDLE with `start`=1:
  - Load A=0, Q=dividend magnitude, M=divisor magnitude, counter=0.
  - If divisor ≠ 0, go to RUN. If divisor = 0, go to FINISH with the zero flag latched.
  - `busy` goes to 1.
- RUN, each edge performs one iteration:
  - {A,Q} <<= 1.
  - T = A − {0,M}.
  - If T[WIDTH] = 1 (negative): restore, keep A, Q[0]=0. Otherwise A=T, Q[0]=1.
  - counter += 1.
  - After the WIDTH-th iteration, go to FINISH.
- FINISH, one edge:
  - Write `quotient`=Q and `remainder`=A[WIDTH-1:0], with sign correction under the macro.
  - `done`=1, `busy`=0, go to IDLE.
- Divide by zero: `quotient` = all ones, `remainder` = dividend unmodified, `div_by_zero`=1.
- `start` while `busy`=1 is ignored. Operand inputs are don't-care after the accepting edge.
- `start` in the cycle where `done`=1 is accepted, so back-to-back operations need no idle gap.
- `rst_n` low at any time, including mid-RUN:
  - Immediately force IDLE.
  - All outputs go to 0: `busy`, `done`, `quotient`, `remainder`, `div_by_zero`.
  - All internal registers are cleared. No partial result is ever presented.

## Timing
- Edge 0 accepts `start`.
- Nonzero divisor:
  - Edges 1..WIDTH iterate.
  - Edge WIDTH+1 raises `done` and updates the result outputs.
  - Latency is WIDTH+1 cycles (9 for WIDTH=8).
- Zero divisor: `done` rises at edge 1, latency 1 cycle.
- `done` is high for exactly one cycle per accepted `start`.
- `busy` is high from edge 0 to edge WIDTH+1 (or to edge 1 for a zero divisor).
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- `RESTORING_DIVIDER_SIGNED_EN` defined:
  - Operands are two's complement.
  - On load, the magnitudes of dividend and divisor go into Q and M.
  - At FINISH, `quotient` is negated if the operand signs differ, and `remainder` takes the dividend's sign (truncating division).
  - The most-negative dividend divided by −1 wraps: `quotient` = 1 followed by WIDTH−1 zeros, `remainder`=0, no flag.
  - Divide by zero gives `quotient` = all ones (−1) and `remainder` = dividend.
  - Latency is unchanged.
- `RESTORING_DIVIDER_SIGNED_EN` undefined: all operands and results are unsigned and no sign logic is built.

## Test plan
- WIDTH=8, unsigned, 100 / 7 → `done` exactly 9 cycles after `start`, `quotient`=14, `remainder`=2, `div_by_zero`=0; `busy` high for 9 cycles.
- 255 / 1 → 255 r 0. 3 / 200 → 0 r 3. 200 / 200 → 1 r 0.
- 5 / 0 → `done` 1 cycle after `start`, `quotient`=8'hFF, `remainder`=5, `div_by_zero`=1.
- `start` pulsed again in the `done` cycle with 50 / 6 → second `done` 9 cycles later with 8 r 2; a `start` pulsed mid-RUN is ignored, giving exactly one `done`.
- `rst_n` low at iteration 4 of 100 / 7 → outputs 0 immediately with no `done` pulse; a later 9 / 2 → 4 r 1.
- With SIGNED_EN: −100 / 7 → 8'hF2 (−14) r 8'hFE (−2); 100 / −7 → −14 r 2; −128 / −1 → 8'h80 r 0.
